// File: rtl/uart_tx_sched_if.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_sched_if
// Brief  : Requester handshakes and uart_tx control bundle for uart_tx_sched.
// Rev    : 1.0  initial release
// ============================================================================
interface uart_tx_sched_if #(
    parameter int FIFO_DEPTH = 4
) ();
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          req0_valid;
    logic [7:0]    req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [7:0]    req1_data;
    logic          req1_ready;
    logic [7:0]    tx_data_out;
    logic          tx_load;
    logic          tx_start;
    logic          tx_finish;
    logic          busy;
    logic          timeout_err;
    logic [CW-1:0] fifo_count;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, tx_finish,
        output req0_ready, req1_ready, tx_data_out, tx_load, tx_start,
               busy, timeout_err, fifo_count
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, tx_finish,
        input  req0_ready, req1_ready, tx_data_out, tx_load, tx_start,
               busy, timeout_err, fifo_count
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_sched
// Brief  : Round-robin two-requester byte queue that sequences uart_tx frames.
// Rev    : 1.0  initial release
// ============================================================================
module uart_tx_sched #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2048,
    parameter int GAP_CYCLES     = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    uart_tx_sched_if.slave   bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          rr_q, rr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [7:0]    tx_data_q, tx_data_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [GW-1:0] gap_q, gap_d;

    logic          full;
    logic          grant0;
    logic          grant1;
    logic          push;
    logic          pop;
    logic [7:0]    push_data;
    logic          tx_load;
    logic          tx_start;
    logic          timeout_err;

    // Full is taken from the registered count, so a pop in the same cycle never frees a slot for a push.
    always_comb begin
        full      = (count_q == FULL_COUNT);
        grant0    = reset_n && !full && bus.req0_valid && (!bus.req1_valid || !rr_q);
        grant1    = reset_n && !full && bus.req1_valid && (!bus.req0_valid ||  rr_q);
        push      = grant0 || grant1;
        push_data = grant0 ? bus.req0_data : bus.req1_data;
        pop       = (state_q == ST_IDLE) && (count_q != '0);
    end

    always_comb begin
        rr_d     = rr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (grant0) begin
            rr_d = 1'b1;
        end else if (grant1) begin
            rr_d = 1'b0;
        end
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        timer_d     = timer_q;
        gap_d       = gap_q;
        tx_load     = 1'b0;
        tx_start    = 1'b0;
        timeout_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    tx_data_d = mem_q[rd_ptr_q];
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_load = 1'b1;
                state_d = ST_START;
            end
            ST_START: begin
                tx_start = 1'b1;
                timer_d  = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                timer_d = timer_q + TW'(1);
                // A finish arriving on the last timer cycle still counts as a clean frame.
                if (bus.tx_finish || (timer_q == TIMER_LAST)) begin
                    timeout_err = !bus.tx_finish;
                    gap_d       = '0;
                    state_d     = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            rr_q      <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            mem_q     <= '{default: '0};
            tx_data_q <= '0;
            timer_q   <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            mem_q     <= mem_d;
            tx_data_q <= tx_data_d;
            timer_q   <= timer_d;
            gap_q     <= gap_d;
        end
    end

    assign bus.req0_ready  = grant0;
    assign bus.req1_ready  = grant1;
    assign bus.tx_data_out = tx_data_q;
    assign bus.tx_load     = tx_load;
    assign bus.tx_start    = tx_start;
    assign bus.busy        = (state_q != ST_IDLE) || (count_q != '0);
    assign bus.timeout_err = timeout_err;
    assign bus.fifo_count  = count_q;

endmodule
`default_nettype wire
